// File: rtl/alu_arbiter.sv
// ============================================================================
// Module      : alu_arbiter
// Description : Two-requester arbiter in front of one shared combinational ALU.
//               It uses a one-entry response register with backpressure.
//               Define ALU_ARB_FIXED_PRIO_EN to give requester 0 fixed priority
//               on ties. The default build uses round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [4:0]        req0_ctrl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [4:0]        req1_ctrl,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [4:0]        alu_control,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_id,
    output logic              rsp_err
);

    localparam logic [0:0] S_EMPTY    = 1'b0;
    localparam logic [0:0] S_FULL     = 1'b1;
    localparam logic [4:0] C_CTRL_MAX = 5'b01110;

    logic [0:0]        r_state;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_id;
    logic              r_rsp_err;
    logic              r_last_grant;

    logic              w_accept;
    logic              w_grant;
    logic              w_grant_idx;
    logic              w_tie_pick;
    logic              w_illegal;
    logic [DATA_W-1:0] w_sel_a;
    logic [DATA_W-1:0] w_sel_b;
    logic [4:0]        w_sel_ctrl;

    // A new operation can land only if the response slot is free or drains this cycle.
    assign w_accept = !rst && ((r_state == S_EMPTY) || rsp_ready);

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign w_tie_pick = 1'b0;
`else
    assign w_tie_pick = ~r_last_grant;
`endif

    assign w_grant_idx = (req0_valid && req1_valid) ? w_tie_pick : req1_valid;
    assign w_grant     = w_accept && (req0_valid || req1_valid);

    assign req0_ready  = w_grant && !w_grant_idx;
    assign req1_ready  = w_grant &&  w_grant_idx;

    always_comb begin
        w_sel_a    = '0;
        w_sel_b    = '0;
        w_sel_ctrl = 5'b00000;
        if (w_grant) begin
            if (w_grant_idx) begin
                w_sel_a    = req1_a;
                w_sel_b    = req1_b;
                w_sel_ctrl = req1_ctrl;
            end else begin
                w_sel_a    = req0_a;
                w_sel_b    = req0_b;
                w_sel_ctrl = req0_ctrl;
            end
        end
    end

    assign alu_a       = w_sel_a;
    assign alu_b       = w_sel_b;
    assign alu_control = w_sel_ctrl;
    assign w_illegal   = (w_sel_ctrl > C_CTRL_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_EMPTY;
            r_rsp_data   <= '0;
            r_rsp_id     <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_grant) begin
            // A grant also covers the drain-and-refill case, so no bubble is inserted.
            r_state      <= S_FULL;
            r_rsp_data   <= w_illegal ? '0 : alu_result;
            r_rsp_id     <= w_grant_idx;
            r_rsp_err    <= w_illegal;
            r_last_grant <= w_grant_idx;
        end else if ((r_state == S_FULL) && rsp_ready) begin
            r_state      <= S_EMPTY;
        end
    end

    assign rsp_valid = (r_state == S_FULL);
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Scoreboard bench for alu_arbiter using directed vectors.
//               A behavioural ALU drives alu_result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef struct packed {
        logic        id;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]  req0_ctrl, req1_ctrl;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [4:0]  alu_control;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [31:0] rsp_data;

    int   checks = 0;
    int   errors = 0;
    rsp_t exp_q[$];

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err)
    );

    // Behavioural ALU; illegal codes return junk so forced-zero data is observable
    always_comb begin
        case (alu_control)
            5'b00000: alu_result = alu_a + alu_b;
            5'b00001: alu_result = alu_a - alu_b;
            5'b00010: alu_result = alu_a & alu_b;
            5'b01000: alu_result = alu_a | alu_b;
            5'b01110: alu_result = alu_a << alu_b[4:0];
            default:  alu_result = 32'hDEAD_0000 | alu_a;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_ops(input logic [31:0] a0, b0, input logic [4:0] c0,
                           input logic [31:0] a1, b1, input logic [4:0] c1);
        req0_a = a0; req0_b = b0; req0_ctrl = c0;
        req1_a = a1; req1_b = b1; req1_ctrl = c1;
    endtask

    // Drive one cycle; gid = expected grant (-1 none), edata/eerr = expected response
    task automatic step(input logic v0, v1, rr, input int gid,
                        input logic [31:0] edata, input logic eerr);
        rsp_t e;
        req0_valid = v0;
        req1_valid = v1;
        rsp_ready  = rr;
        #1;
        check("req0_ready", {31'b0, req0_ready}, {31'b0, gid == 0});
        check("req1_ready", {31'b0, req1_ready}, {31'b0, gid == 1});
        if (gid >= 0) begin
            check("alu_control", {27'b0, alu_control}, {27'b0, (gid == 1) ? req1_ctrl : req0_ctrl});
            e.id   = (gid == 1);
            e.data = edata;
            e.err  = eerr;
            exp_q.push_back(e);
        end else begin
            check("alu_a_idle", alu_a, 32'h0);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic tie(input int rr_id, input logic [31:0] d0, d1);
        int g;
        g = FIXED ? 0 : rr_id;
        step(1'b1, 1'b1, 1'b1, g, (g == 1) ? d1 : d0, 1'b0);
    endtask

    // Monitor: a response is consumed when valid and ready are both high
    initial begin
        rsp_t e;
        forever begin
            @(posedge clk);
            #4;
            if (!rst && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got id=%0d data=0x%08h, expected none", rsp_id, rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_id", {31'b0, rsp_id}, {31'b0, e.id});
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        set_ops(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #2;
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("rst_rsp_data", rsp_data, 32'h0);
        rst = 1'b0;

        // Both requesters valid from reset: 0 wins first, then alternation
        set_ops(5, 3, 5'b00000, 9, 4, 5'b00001);
        tie(0, 32'd8, 32'd5);
        tie(1, 32'd8, 32'd5);
        set_ops(10, 20, 5'b00000, 100, 1, 5'b00001);
        for (int i = 0; i < 6; i++) tie(i % 2, 32'd30, 32'd99);
        step(1'b0, 1'b0, 1'b1, -1, 0, 1'b0);
        check("drained", {31'b0, rsp_valid}, 32'h0);

        // Backpressure: hold 0xFF for three stall cycles
        set_ops(32'hF0, 32'h0F, 5'b01000, 0, 0, 5'b00000);
        step(1'b1, 1'b0, 1'b1, 0, 32'hFF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, -1, 0, 1'b0);
            check("stall_valid", {31'b0, rsp_valid}, 32'h1);
            check("stall_data", rsp_data, 32'hFF);
            check("stall_id", {31'b0, rsp_id}, 32'h0);
        end
        step(1'b1, 1'b0, 1'b1, 0, 32'hFF, 1'b0);

        // Single requester 1, then illegal and boundary control codes
        set_ops(0, 0, 5'b00000, 7, 2, 5'b00001);
        step(1'b0, 1'b1, 1'b1, 1, 32'd5, 1'b0);
        set_ops(0, 0, 5'b00000, 1, 1, 5'b11111);
        step(1'b0, 1'b1, 1'b1, 1, 32'd0, 1'b1);
        set_ops(6, 3, 5'b01110, 0, 0, 5'b00000);
        step(1'b1, 1'b0, 1'b1, 0, 32'd48, 1'b0);
        set_ops(1, 1, 5'b01111, 0, 0, 5'b00000);
        step(1'b1, 1'b0, 1'b1, 0, 32'd0, 1'b1);

        // Requester 1 raises and drops valid during a stall without being granted
        set_ops(3, 4, 5'b00000, 12, 10, 5'b00010);
        step(1'b0, 1'b1, 1'b0, -1, 0, 1'b0);
        check("drop_hold_err", {31'b0, rsp_err}, 32'h1);
        step(1'b0, 1'b0, 1'b1, -1, 0, 1'b0);
        tie(1, 32'd7, 32'd8);

        // Reset with a held response and both requesters valid
        set_ops(2, 2, 5'b00000, 0, 0, 5'b00000);
        step(1'b1, 1'b0, 1'b1, 0, 32'd4, 1'b0);
        step(1'b1, 1'b1, 1'b0, -1, 0, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_req0_ready", {31'b0, req0_ready}, 32'h0);
        check("rst_req1_ready", {31'b0, req1_ready}, 32'h0);
        check("rst_alu_ctrl", {27'b0, alu_control}, 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        exp_q.delete();
        check("post_rst_valid", {31'b0, rsp_valid}, 32'h0);
        check("post_rst_data", rsp_data, 32'h0);
        set_ops(5, 3, 5'b00000, 9, 4, 5'b00001);
        tie(0, 32'd8, 32'd5);
        tie(1, 32'd8, 32'd5);
        step(1'b0, 1'b0, 1'b1, -1, 0, 1'b0);
        step(1'b0, 1'b0, 1'b1, -1, 0, 1'b0);
        check("final_valid", {31'b0, rsp_valid}, 32'h0);
        check("queue_empty", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid / req1_valid  input  1  requester n has an operation pending.
REQ-005 req0_ready / req1_ready  output  1  requester n's operation is accepted this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  DATA_W  operands of requester n.
REQ-007 req0_ctrl / req1_ctrl  input  5  ALU control code of requester n, same encoding as the ALU control input.
REQ-008 alu_a, alu_b  output  DATA_W  operands driven to the shared ALU.
REQ-009 alu_control  output  5  control code driven to the shared ALU.
REQ-010 alu_result  input  DATA_W  combinational result from the shared ALU.
REQ-011 rsp_valid  output  1  response register holds a result.
REQ-012 rsp_ready  input  1  consumer takes the response this cycle.
REQ-013 rsp_data  output  DATA_W  captured result.
REQ-014 rsp_id  output  1  requester that owns the response (0 or 1).
REQ-015 rsp_err  output  1  the control code was illegal (greater than 5'b01110).

Function
REQ-016 Accept condition: accept = !rsp_valid || rsp_ready; no request is granted when accept is 0.
REQ-017 When accept is 1 and exactly one reqN_valid is high, grant that requester.
REQ-018 When accept is 1 and both valids are high, grant the requester not granted last (round-robin via 1-bit last_grant pointer).
REQ-019 reqN_ready is high only for the granted requester, in the grant cycle; it is a combinational function of valids, last_grant, rsp_valid and rsp_ready.
REQ-020 alu_a/alu_b/alu_control carry the granted requester's operands in the grant cycle; otherwise alu_a = alu_b = 0 and alu_control = 5'b00000.
REQ-021 On a grant edge: rsp_data <= alu_result (or 0 if illegal), rsp_id <= granted index, rsp_err <= (ctrl > 5'b01110), rsp_valid <= 1, last_grant <= granted index.
REQ-022 Latency: response is visible one cycle after acceptance; sustained throughput is one operation per cycle while rsp_ready stays high.
REQ-023 rsp_valid with rsp_ready high and no new grant: rsp_valid <= 0 next edge; rsp_data/rsp_id/rsp_err hold their values.
REQ-024 rsp_valid high and rsp_ready low: rsp_data, rsp_id and rsp_err are held stable, and both reqN_ready are 0 (backpressure).
REQ-025 Drain and grant in the same cycle: the response register is overwritten with the new result and rsp_valid stays 1 (no bubble).
REQ-026 Illegal ctrl is still granted and consumed (ready pulses); rsp_err = 1 and rsp_data = 0.
REQ-027 A requester may drop valid without being granted; no state changes in that case.
REQ-028 Effective states: EMPTY (rsp_valid = 0) and FULL (rsp_valid = 1). EMPTY->FULL on grant; FULL->EMPTY on rsp_ready with no grant; FULL->FULL on stall, or on rsp_ready with a grant.

Reset
REQ-029 While rst is high at a clock edge: rsp_valid = 0, rsp_data = 0, rsp_id = 0, rsp_err = 0, last_grant = 1.
REQ-030 While rst is high, both reqN_ready are 0 and ALU outputs are 0; an in-flight response is discarded.
REQ-031 Because last_grant resets to 1, requester 0 wins the first simultaneous request after reset.

Configuration
REQ-032 Macro ALU_ARB_FIXED_PRIO_EN defined: requester 0 always wins ties; last_grant still updates but is ignored.
REQ-033 Macro ALU_ARB_FIXED_PRIO_EN undefined: round-robin arbitration per REQ-018.

Verification
REQ-034 Reset, then both valid, req0 = (5, 3, 5'b00000), req1 = (9, 4, 5'b00001), rsp_ready = 1 -> cycle 1: rsp_id = 0, data = 8; cycle 2: rsp_id = 1, data = 5.
REQ-035 Both requesters continuously valid for 6 cycles, rsp_ready = 1 -> grants alternate 0,1,0,1,0,1 (with FIXED_PRIO_EN: all 0).
REQ-036 req0 = (0xF0, 0x0F, 5'b01000), rsp_ready = 0 for 3 cycles -> rsp_data = 0xFF held, req0_ready = 0 during the stall, accepted again the cycle rsp_ready rises.
REQ-037 req1 with ctrl 5'b11111, A = 1, B = 1 -> req1_ready pulses, rsp_err = 1, rsp_data = 0, rsp_id = 1.
REQ-038 rst asserted while rsp_valid = 1 and both valids high -> next cycle rsp_valid = 0, no ready; after release req0 is granted first.
